// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: op encoding, sequencer states, flag bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package control_signals;

  // Operation encoding understood by the 8-bit alu instance.
  typedef enum logic [2:0] {
    ALU_ADD         = 3'd0,
    ALU_AND         = 3'd1,
    ALU_OR          = 3'd2,
    ALU_XOR         = 3'd3,
    ALU_SHIFT_LEFT  = 3'd4,
    ALU_SHIFT_RIGHT = 3'd5
  } alu_op_t;

  // Sequencer passes: low byte, high byte, optional BCD fix-up, then response.
  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_LO   = 3'd1,
    SEQ_HI   = 3'd2,
    SEQ_DEC  = 3'd3,
    SEQ_DONE = 3'd4
  } alu_seq_state_t;

  // Result flags, packed in {N,V,Z,C} order to match the response port.
  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } alu_flags_t;

  // True when an op in this pass feeds its carry into the next byte.
  function automatic logic chains_carry(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SHIFT_LEFT);
  endfunction

endpackage

// File: rtl/alu_sequencer_bcd_correct.sv
// BCD fix-up byte for a narrow add/subtract, derived from the latched operands.
// Latency: combinational.
// Backpressure: none; only instantiated when ALU_SEQ_DECIMAL_EN is defined.
module bcd_correct (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic       invert_b,
  output logic [7:0] correction,
  output logic       dec_carry
);

  logic [7:0] b_eff;
  logic [4:0] lo_sum;
  logic [8:0] sum;
  logic       half_carry;
  logic       lo_adj;
  logic       hi_adj;

  // Recompute the binary pass locally so the fix-up needs no extra ALU state.
  always_comb begin
    b_eff      = invert_b ? ~b : b;
    lo_sum     = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, carry_in};
    sum        = {1'b0, a} + {1'b0, b_eff} + {8'b0, carry_in};
    half_carry = lo_sum[4];
  end

  // Add fixes nibbles that overflowed decimal range; subtract fixes nibbles that borrowed.
  // The high test uses >0x99 so a low-nibble fix rippling into the high nibble is caught.
  always_comb begin
    if (invert_b) begin
      lo_adj    = !half_carry;
      hi_adj    = !sum[8];
      dec_carry = sum[8];
    end else begin
      lo_adj    = half_carry || (sum[3:0] > 4'd9);
      hi_adj    = sum[8] || (sum[7:0] > 8'h99);
      dec_carry = hi_adj;
    end
    correction = (lo_adj ? (invert_b ? 8'hFA : 8'h06) : 8'h00)
               + (hi_adj ? (invert_b ? 8'hA0 : 8'h60) : 8'h00);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the shared 8-bit ALU for narrow, wide and (with ALU_SEQ_DECIMAL_EN) BCD ops.
// Latency: accept->rsp_valid 2 cycles narrow, 3 cycles wide or decimal.
// Backpressure: req_ready only in IDLE; requests while busy are dropped, not queued.
module alu_sequencer
  import control_signals::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  alu_op_t     req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_carry,
  input  logic        req_invert_b,
  input  logic        req_decimal,
  output logic        rsp_valid,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output alu_op_t     alu_operation,
  output logic [7:0]  alu_input_a,
  output logic [7:0]  alu_input_b,
  output logic        alu_carry_in,
  output logic        alu_invert_b,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_negative
);

  alu_seq_state_t state_q, state_d;

  alu_op_t    op_q;
  logic       wide_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic       carry_q;
  logic       invert_q;
  logic [7:0] lo_byte_q;
  logic       lo_carry_q;
  alu_flags_t rsp_flags_q;

`ifdef ALU_SEQ_DECIMAL_EN
  logic       dec_q;
  logic       lo_v_q;
  logic [7:0] bcd_corr;
  logic       bcd_carry;

  bcd_correct u_bcd_correct (
    .a          (a_q[7:0]),
    .b          (b_q[7:0]),
    .carry_in   (carry_q),
    .invert_b   (invert_q),
    .correction (bcd_corr),
    .dec_carry  (bcd_carry)
  );
`else
  logic decimal_unused;
  assign decimal_unused = req_decimal;
`endif

  assign rsp_flags = rsp_flags_q;

  // State register; reset always lands in IDLE and abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEQ_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and ALU drive: each pass presents its byte slice to the ALU.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    alu_operation = ALU_ADD;
    alu_input_a   = 8'h00;
    alu_input_b   = 8'h00;
    alu_carry_in  = 1'b0;
    alu_invert_b  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_d = SEQ_LO;
      end
      SEQ_LO: begin
        alu_operation = op_q;
        alu_input_a   = a_q[7:0];
        alu_input_b   = b_q[7:0];
        alu_carry_in  = carry_q;
        alu_invert_b  = invert_q;
        if (wide_q) state_d = SEQ_HI;
`ifdef ALU_SEQ_DECIMAL_EN
        else if (dec_q) state_d = SEQ_DEC;
`endif
        else state_d = SEQ_DONE;
      end
      SEQ_HI: begin
        alu_operation = op_q;
        alu_input_a   = a_q[15:8];
        alu_input_b   = b_q[15:8];
        alu_carry_in  = chains_carry(op_q) ? lo_carry_q : carry_q;
        alu_invert_b  = invert_q;
        state_d       = SEQ_DONE;
      end
      SEQ_DEC: begin
`ifdef ALU_SEQ_DECIMAL_EN
        alu_operation = ALU_ADD;
        alu_input_a   = lo_byte_q;
        alu_input_b   = bcd_corr;
        state_d       = SEQ_DONE;
`else
        state_d       = SEQ_IDLE;
`endif
      end
      SEQ_DONE: begin
        rsp_valid = 1'b1;
        state_d   = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Datapath: latch the request, keep the low pass, publish on the final pass only
  // so the response registers hold steady between DONE pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= ALU_ADD;
      wide_q      <= 1'b0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      carry_q     <= 1'b0;
      invert_q    <= 1'b0;
      lo_byte_q   <= 8'h00;
      lo_carry_q  <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_flags_q <= '0;
`ifdef ALU_SEQ_DECIMAL_EN
      dec_q       <= 1'b0;
      lo_v_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            wide_q   <= req_wide;
            a_q      <= req_a;
            b_q      <= req_b;
            carry_q  <= req_carry;
            invert_q <= req_invert_b;
`ifdef ALU_SEQ_DECIMAL_EN
            // Decimal only makes sense for a narrow add/subtract.
            dec_q    <= req_decimal && !req_wide && (req_op == ALU_ADD);
`endif
          end
        end
        SEQ_LO: begin
          lo_byte_q  <= alu_out;
          lo_carry_q <= alu_carry;
`ifdef ALU_SEQ_DECIMAL_EN
          lo_v_q     <= alu_overflow;
          if (!wide_q && !dec_q) begin
`else
          if (!wide_q) begin
`endif
            rsp_result  <= {8'h00, alu_out};
            rsp_flags_q <= '{n: alu_negative, v: alu_overflow, z: alu_zero, c: alu_carry};
          end
        end
        SEQ_HI: begin
          rsp_result  <= {alu_out, lo_byte_q};
          rsp_flags_q <= '{n: alu_negative, v: alu_overflow,
                           z: alu_zero && (lo_byte_q == 8'h00), c: alu_carry};
        end
`ifdef ALU_SEQ_DECIMAL_EN
        SEQ_DEC: begin
          rsp_result  <= {8'h00, alu_out};
          rsp_flags_q <= '{n: alu_negative, v: lo_v_q, z: alu_zero, c: bcd_carry};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU and a result scoreboard.
module tb_alu_sequencer;
  import control_signals::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  alu_op_t     req_op;
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_carry;
  logic        req_invert_b;
  logic        req_decimal;
  logic        rsp_valid;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  alu_op_t     alu_operation;
  logic [7:0]  alu_input_a;
  logic [7:0]  alu_input_b;
  logic        alu_carry_in;
  logic        alu_invert_b;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_negative;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_wide      (req_wide),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_carry     (req_carry),
    .req_invert_b  (req_invert_b),
    .req_decimal   (req_decimal),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .alu_operation (alu_operation),
    .alu_input_a   (alu_input_a),
    .alu_input_b   (alu_input_b),
    .alu_carry_in  (alu_carry_in),
    .alu_invert_b  (alu_invert_b),
    .alu_out       (alu_out),
    .alu_carry     (alu_carry),
    .alu_overflow  (alu_overflow),
    .alu_zero      (alu_zero),
    .alu_negative  (alu_negative)
  );

  // Behavioural model of the external 8-bit ALU.
  logic [7:0] bb;
  logic [8:0] sum9;
  always_comb begin
    bb           = alu_invert_b ? ~alu_input_b : alu_input_b;
    sum9         = {1'b0, alu_input_a} + {1'b0, bb} + {8'b0, alu_carry_in};
    alu_out      = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_operation)
      ALU_ADD: begin
        alu_out      = sum9[7:0];
        alu_carry    = sum9[8];
        alu_overflow = (alu_input_a[7] == bb[7]) && (sum9[7] != alu_input_a[7]);
      end
      ALU_AND:         alu_out = alu_input_a & bb;
      ALU_OR:          alu_out = alu_input_a | bb;
      ALU_XOR:         alu_out = alu_input_a ^ bb;
      ALU_SHIFT_LEFT:  begin alu_out = {alu_input_a[6:0], alu_carry_in}; alu_carry = alu_input_a[7]; end
      ALU_SHIFT_RIGHT: begin alu_out = {alu_carry_in, alu_input_a[7:1]}; alu_carry = alu_input_a[0]; end
      default: ;
    endcase
    alu_zero     = (alu_out == 8'h00);
    alu_negative = alu_out[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic wide, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic inv, input logic dec);
    req_op = op; req_wide = wide; req_a = a; req_b = b;
    req_carry = c; req_invert_b = inv; req_decimal = dec;
  endtask

  // Pops the next expected response and compares it against the DUT outputs.
  task automatic compare_rsp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL %s: response with empty scoreboard, observed %0h", tag, rsp_result);
    end else begin
      e = sb_q.pop_front();
      check({tag, " result"}, 32'(rsp_result), 32'(e.res));
      check({tag, " flags"}, 32'(rsp_flags), 32'(e.flg));
    end
  endtask

  // Issues one request from a negedge, measures accept->rsp_valid, scores the response.
  task automatic run_op(input string tag, input alu_op_t op, input logic wide,
                        input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic inv, input logic dec, input logic [15:0] er,
                        input logic [3:0] ef, input int elat, output logic hi_cin);
    int lat;
    sb_q.push_back('{res: er, flg: ef});
    drive(op, wide, a, b, c, inv, dec);
    req_valid = 1'b1;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    hi_cin = 1'b0;
    while (!rsp_valid && lat < 8) begin
      if (lat == 1) check({tag, " busy"}, 32'(req_ready), 32'd0);
      if (lat == 2) hi_cin = alu_carry_in;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    if (rsp_valid) compare_rsp(tag);
    else void'(sb_q.pop_front());
    @(negedge clk);
    check({tag, " pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, " hold"}, 32'(rsp_result), 32'(er));
  endtask

  int   dec_lat;
  logic hc;
  logic saw_rsp;

  initial begin
    rst = 1'b1; req_valid = 1'b0;
    drive(ALU_ADD, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst result", 32'(rsp_result), 32'd0);
    check("rst flags", 32'(rsp_flags), 32'd0);
    check("rst alu op", 32'(alu_operation), 32'(ALU_ADD));
    check("rst alu ab", {16'h0, alu_input_a, alu_input_b}, 32'd0);
    check("rst alu ci", {30'd0, alu_carry_in, alu_invert_b}, 32'd0);
    rst = 1'b0;
    #1 check("post rst ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    run_op("narrow add", ALU_ADD, 1'b0, 16'h0006, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h000C, 4'b0000, 2, hc);
    run_op("narrow upper ignored", ALU_ADD, 1'b0, 16'h55AA, 16'h3356, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0011, 2, hc);
    run_op("wide add", ALU_ADD, 1'b1, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h1300, 4'b0000, 3, hc);
    check("wide add hi carry_in", 32'(hc), 32'd1);
    run_op("wide sub", ALU_ADD, 1'b1, 16'h0100, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h00FF, 4'b0001, 3, hc);
    check("wide sub hi carry_in", 32'(hc), 32'd0);
    run_op("wide zero", ALU_ADD, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0011, 3, hc);
    run_op("wide v from hi", ALU_ADD, 1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0, 16'h0100, 4'b0000, 3, hc);
    run_op("narrow shl", ALU_SHIFT_LEFT, 1'b0, 16'h00C3, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0086, 4'b1001, 2, hc);
    run_op("wide shl", ALU_SHIFT_LEFT, 1'b1, 16'h8081, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0102, 4'b0001, 3, hc);
    check("wide shl hi carry_in", 32'(hc), 32'd1);
    run_op("wide xor", ALU_XOR, 1'b1, 16'h0F0F, 16'h00FF, 1'b1, 1'b0, 1'b0, 16'h0FF0, 4'b0000, 3, hc);
    check("wide xor hi carry_in", 32'(hc), 32'd1);

`ifdef ALU_SEQ_DECIMAL_EN
    dec_lat = 3;
    run_op("dec 19+28", ALU_ADD, 1'b0, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1, 16'h0047, 4'b0000, dec_lat, hc);
    run_op("dec 99+01", ALU_ADD, 1'b0, 16'h0099, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0011, dec_lat, hc);
`else
    dec_lat = 2;
    run_op("dec 19+28", ALU_ADD, 1'b0, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1, 16'h0041, 4'b0000, dec_lat, hc);
    run_op("dec 99+01", ALU_ADD, 1'b0, 16'h0099, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h009A, 4'b1000, dec_lat, hc);
`endif
    run_op("dec wide binary", ALU_ADD, 1'b1, 16'h0019, 16'h0028, 1'b0, 1'b0, 1'b1, 16'h0041, 4'b0000, 3, hc);

    // Held request during LO/DONE must not be taken until the sequencer is idle again.
    sb_q.push_back('{res: 16'h0030, flg: 4'b0000});
    drive(ALU_ADD, 1'b0, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1;
    @(negedge clk);
    check("hold busy", 32'(req_ready), 32'd0);
    drive(ALU_ADD, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold first rsp", 32'(rsp_valid), 32'd1);
    if (rsp_valid) compare_rsp("hold first");
    else void'(sb_q.pop_front());
    sb_q.push_back('{res: 16'h0002, flg: 4'b0000});
    @(negedge clk);
    check("hold idle ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("hold second rsp", 32'(rsp_valid), 32'd1);
    if (rsp_valid) compare_rsp("hold second");
    else void'(sb_q.pop_front());
    @(negedge clk);

    // Reset during the HI pass discards the op.
    drive(ALU_ADD, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst hi ready low", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 check("rst hi ready", 32'(req_ready), 32'd1);
    check("rst hi result", 32'(rsp_result), 32'd0);
    saw_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("rst hi no rsp", 32'(saw_rsp), 32'd0);

    run_op("post rst add", ALU_ADD, 1'b0, 16'h0040, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0080, 4'b1100, 2, hc);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
